controle_verificacao: RTL

Sequencing controller for the electronic lock's shared password verifier. It captures one typed attempt and replays it against every enabled stored password slot through the single verifier datapath, one slot at a time. It reports which slot matched, counts consecutive failures, and enforces a timed lockout. It sits between the keypad/entry logic (upstream) and the verifier instance plus the door actuator logic (downstream).

---
 rtl/controle_verificacao_pkg.sv | 22 ++
 rtl/controle_verificacao_temporizador_bloqueio.sv | 35 +++
 rtl/controle_verificacao.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/controle_verificacao_pkg.sv
// Shared types for the password verification controller.
//   senhaPac_t     : packed password, DIGITOS BCD digits of 4 bits each.
//   SENHA_VAZIA    : "blank" password value (all digits 4'hF), used as reset value.
//   estado_ctrl_t  : controller state encoding.
package controle_verificacao_pkg;

  localparam int unsigned DIGITOS = 6;
  localparam int unsigned DIG_W   = 4;

  typedef logic [DIGITOS-1:0][DIG_W-1:0] senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA = {DIGITOS{4'hF}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPARA,
    ST_ESPERA,
    ST_RESULT,
    ST_BLOQUEIO
  } estado_ctrl_t;

endpackage

// File: rtl/controle_verificacao_temporizador_bloqueio.sv
// Lockout timer: loadable 8-bit down-counter that stops at zero.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : load T_BLOQ (has priority over tick)
//   tick         : decrement by one when non-zero
//   tempo_rest   : remaining ticks (registered)
//   zero         : counter is zero (decoded from the register)
module controle_verificacao_temporizador_bloqueio #(
  parameter int unsigned T_BLOQ = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       tick,
  output logic [7:0] tempo_rest,
  output logic       zero
);

  logic [7:0] tempo_q;

  // Load wins so a tick coinciding with lockout entry is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tempo_q <= 8'd0;
    end else if (load) begin
      tempo_q <= 8'(T_BLOQ);
    end else if (tick && (tempo_q != 8'd0)) begin
      tempo_q <= tempo_q - 8'd1;
    end
  end

  assign tempo_rest = tempo_q;
  assign zero       = (tempo_q == 8'd0);

endmodule

// File: rtl/controle_verificacao.sv
// Sequencing controller for the shared password verifier.
// Captures one attempt and replays it against every enabled slot, lowest
// first, through a single external verifier; reports the matching slot,
// counts consecutive failures and enforces a timed lockout.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   tick                       : 1 s time base for the lockout
//   valid_in, senha_teste      : new attempt (pulse) and its value
//   senhas, slot_en            : stored passwords and per-slot enable
//   vs_valid, vs_senha_teste,
//   vs_senha_real              : start pulse and operands to the verifier
//   vs_done, vs_senha_ok       : verifier completion and result
//   busy, done, senha_ok,
//   slot_idx                   : attempt status and result
//   rejeitado                  : valid_in arrived while not idle
//   bloqueado, tentativas,
//   tempo_rest                 : lockout status, failure count, ticks left
module controle_verificacao
  import controle_verificacao_pkg::*;
#(
  parameter int unsigned N_SLOTS  = 5,
  parameter int unsigned MAX_TENT = 3,
  parameter int unsigned T_BLOQ   = 30,
  parameter int unsigned T_WDOG   = 64,
  localparam int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              valid_in,
  input  senhaPac_t         senha_teste,
  input  senhaPac_t         senhas [N_SLOTS],
  input  logic [N_SLOTS-1:0] slot_en,
  output logic              vs_valid,
  output senhaPac_t         vs_senha_teste,
  output senhaPac_t         vs_senha_real,
  input  logic              vs_done,
  input  logic              vs_senha_ok,
  output logic              busy,
  output logic              done,
  output logic              senha_ok,
  output logic [IDX_W-1:0]  slot_idx,
  output logic              rejeitado,
  output logic              bloqueado,
  output logic [3:0]        tentativas,
  output logic [7:0]        tempo_rest
);

  localparam int unsigned WDOG_W = $clog2(T_WDOG + 1);

  estado_ctrl_t      estado_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              vs_valid_q;
  senhaPac_t         vs_senha_teste_q;
  senhaPac_t         vs_senha_real_q;
  logic              done_q;
  logic              senha_ok_q;
  logic [IDX_W-1:0]  slot_idx_q;
  logic              rejeitado_q;
  logic [3:0]        tentativas_q;

  logic              prim_ok;
  logic [IDX_W-1:0]  prim_idx;
  senhaPac_t         prim_senha;
  logic              prox_ok;
  logic [IDX_W-1:0]  prox_idx;
  senhaPac_t         prox_senha;
  logic [3:0]        tent_falha;
  logic              wdog_fim;
  logic              carrega_bloq;
  logic              tick_bloq;
  logic              tempo_zero;

  // Slot selection: lowest enabled slot, and lowest enabled slot above idx_q.
  always_comb begin
    prim_ok    = 1'b0;
    prim_idx   = '0;
    prim_senha = senhas[0];
    prox_ok    = 1'b0;
    prox_idx   = '0;
    prox_senha = senhas[0];
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (slot_en[i] && !prim_ok) begin
        prim_ok    = 1'b1;
        prim_idx   = IDX_W'(i);
        prim_senha = senhas[i];
      end
      if (slot_en[i] && !prox_ok && (i > 32'(idx_q))) begin
        prox_ok    = 1'b1;
        prox_idx   = IDX_W'(i);
        prox_senha = senhas[i];
      end
    end
  end

  // Failure count saturates at MAX_TENT.
  assign tent_falha = (tentativas_q < 4'(MAX_TENT)) ? (tentativas_q + 4'd1) : tentativas_q;
  assign wdog_fim   = (wdog_q == WDOG_W'(T_WDOG - 1));

  assign carrega_bloq = (estado_q == ST_RESULT) && (tentativas_q == 4'(MAX_TENT));
  assign tick_bloq    = tick && (estado_q == ST_BLOQUEIO);

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q         <= ST_IDLE;
      idx_q            <= '0;
      wdog_q           <= '0;
      vs_valid_q       <= 1'b0;
      vs_senha_teste_q <= SENHA_VAZIA;
      vs_senha_real_q  <= SENHA_VAZIA;
      done_q           <= 1'b0;
      senha_ok_q       <= 1'b0;
      slot_idx_q       <= '0;
      rejeitado_q      <= 1'b0;
      tentativas_q     <= 4'd0;
    end else begin
      vs_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      rejeitado_q <= valid_in && (estado_q != ST_IDLE);

      unique case (estado_q)
        ST_IDLE: begin
          if (valid_in) begin
            vs_senha_teste_q <= senha_teste;
            if (prim_ok) begin
              // Operand is latched together with the start pulse.
              idx_q           <= prim_idx;
              vs_senha_real_q <= prim_senha;
              vs_valid_q      <= 1'b1;
              estado_q        <= ST_DISPARA;
            end else begin
              done_q       <= 1'b1;
              senha_ok_q   <= 1'b0;
              slot_idx_q   <= '0;
              tentativas_q <= tent_falha;
              estado_q     <= ST_RESULT;
            end
          end
        end

        ST_DISPARA: begin
          wdog_q   <= '0;
          estado_q <= ST_ESPERA;
        end

        ST_ESPERA: begin
          if (vs_done && vs_senha_ok) begin
            done_q       <= 1'b1;
            senha_ok_q   <= 1'b1;
            slot_idx_q   <= idx_q;
            tentativas_q <= 4'd0;
            estado_q     <= ST_RESULT;
          end else if (vs_done || wdog_fim) begin
            // Mismatch or silent verifier: move on to the next slot.
            if (prox_ok) begin
              idx_q           <= prox_idx;
              vs_senha_real_q <= prox_senha;
              vs_valid_q      <= 1'b1;
              estado_q        <= ST_DISPARA;
            end else begin
              done_q       <= 1'b1;
              senha_ok_q   <= 1'b0;
              slot_idx_q   <= '0;
              tentativas_q <= tent_falha;
              estado_q     <= ST_RESULT;
            end
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end

        ST_RESULT: begin
          estado_q <= carrega_bloq ? ST_BLOQUEIO : ST_IDLE;
        end

        ST_BLOQUEIO: begin
          if (tempo_zero) begin
            tentativas_q <= 4'd0;
            estado_q     <= ST_IDLE;
          end
        end

        default: estado_q <= ST_IDLE;
      endcase
    end
  end

  controle_verificacao_temporizador_bloqueio #(
    .T_BLOQ (T_BLOQ)
  ) u_temporizador_bloqueio (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (carrega_bloq),
    .tick       (tick_bloq),
    .tempo_rest (tempo_rest),
    .zero       (tempo_zero)
  );

  assign vs_valid       = vs_valid_q;
  assign vs_senha_teste = vs_senha_teste_q;
  assign vs_senha_real  = vs_senha_real_q;
  assign done           = done_q;
  assign senha_ok       = senha_ok_q;
  assign slot_idx       = slot_idx_q;
  assign rejeitado      = rejeitado_q;
  assign tentativas     = tentativas_q;
  assign busy           = (estado_q == ST_DISPARA) || (estado_q == ST_ESPERA) ||
                          (estado_q == ST_RESULT);
  assign bloqueado      = (estado_q == ST_BLOQUEIO);

endmodule
